sprite_line_sched: RTL and testbench

Per-scanline sprite fetch scheduler for the racing-game video pipeline. During horizontal blanking it walks all sprite slots in fixed order and decides which sprites intersect the upcoming line. For each intersecting sprite it reads one bitmap row from a shared, single-port, registered sprite ROM (car image). It then publishes all rows at once as a double-buffered line set, so the pixel mixer never sees a partially updated line.

---
 rtl/sprite_line_sched_if.sv | 22 ++
 rtl/sprite_line_sched.sv | 146 ++++++++++++++
 tb/tb_sprite_line_sched.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_line_sched_if.sv
// Sprite ROM read port: single port, registered,
// data returns one cycle after the read strobe.
interface sprite_line_sched_if #(
  parameter int AW = 6,
  parameter int DW = 8
);
  logic          rom_rd;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;

  modport master (
    output rom_rd,
    output rom_addr,
    input  rom_data
  );

  modport slave (
    input  rom_rd,
    input  rom_addr,
    output rom_data
  );
endinterface

// File: rtl/sprite_line_sched.sv
// Per-scanline sprite fetch scheduler: walks sprite slots in
// hblank, fetches one ROM row per hit, publishes a line set.
module sprite_line_sched #(
  parameter int SPR_N = 2,
  parameter int SPR_W = 8,
  parameter int SPR_H = 16,
  parameter int IMG_W = 2,
  parameter int Y_W   = 10
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   line_start,
  input  logic [Y_W-1:0]         vpos,
  input  logic [SPR_N*Y_W-1:0]   spr_y,
  input  logic [SPR_N*IMG_W-1:0] spr_img,
  input  logic [SPR_N-1:0]       spr_en,
  sprite_line_sched_if.master    rom,
  output logic [SPR_N*SPR_W-1:0] row_data,
  output logic [SPR_N-1:0]       row_hit,
  output logic                   busy,
  output logic                   done,
  output logic                   overrun
);

  localparam int ROW_W = $clog2(SPR_H);
  localparam int IDX_W = (SPR_N > 1) ? $clog2(SPR_N) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CHECK  = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_COMMIT = 2'd3;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SPR_N - 1);
  localparam logic [Y_W-1:0]   H_LIM    = Y_W'(SPR_H);

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [Y_W-1:0]   vl_q, vl_d;

  logic [SPR_N-1:0][SPR_W-1:0] stg_row_q, stg_row_d;
  logic [SPR_N-1:0][SPR_W-1:0] pub_row_q, pub_row_d;
  logic [SPR_N-1:0]            stg_hit_q, stg_hit_d;
  logic [SPR_N-1:0]            pub_hit_q, pub_hit_d;

  logic done_q, done_d;
  logic ovr_q, ovr_d;

  logic [Y_W-1:0]   cur_y;
  logic [Y_W-1:0]   diff;
  logic [IMG_W-1:0] cur_img;
  logic             hit;
  logic             last;

  // Sprite attributes are read live, not latched per line
  assign cur_y   = spr_y[idx_q*Y_W +: Y_W];
  assign cur_img = spr_img[idx_q*IMG_W +: IMG_W];
  assign diff    = vl_q - cur_y;
  assign hit     = spr_en[idx_q] && (diff < H_LIM);
  assign last    = (idx_q == IDX_LAST);

  assign rom.rom_rd   = (state_q == S_CHECK) && hit;
  assign rom.rom_addr = rom.rom_rd
                      ? {cur_img, diff[ROW_W-1:0]}
                      : '0;

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign overrun  = ovr_q;
  assign row_data = pub_row_q;
  assign row_hit  = pub_hit_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    vl_d      = vl_q;
    stg_row_d = stg_row_q;
    stg_hit_d = stg_hit_q;
    pub_row_d = pub_row_q;
    pub_hit_d = pub_hit_q;
    done_d    = 1'b0;
    ovr_d     = ovr_q | (line_start && busy);

    unique case (state_q)
      S_IDLE: begin
        if (line_start) begin
          vl_d    = vpos;
          idx_d   = '0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (hit) begin
          state_d = S_WAIT;
        end else begin
          stg_row_d[idx_q] = '0;
          stg_hit_d[idx_q] = 1'b0;
          if (last) state_d = S_COMMIT;
          else      idx_d   = idx_q + 1'b1;
        end
      end
      S_WAIT: begin
        stg_row_d[idx_q] = rom.rom_data;
        stg_hit_d[idx_q] = 1'b1;
        if (last) begin
          state_d = S_COMMIT;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_CHECK;
        end
      end
      S_COMMIT: begin
        // Whole line set swaps in one edge
        pub_row_d = stg_row_q;
        pub_hit_d = stg_hit_q;
        done_d    = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      vl_q      <= '0;
      stg_row_q <= '0;
      stg_hit_q <= '0;
      pub_row_q <= '0;
      pub_hit_q <= '0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      vl_q      <= vl_d;
      stg_row_q <= stg_row_d;
      stg_hit_q <= stg_hit_d;
      pub_row_q <= pub_row_d;
      pub_hit_q <= pub_hit_d;
      done_q    <= done_d;
      ovr_q     <= ovr_d;
    end
  end

endmodule

// File: tb/tb_sprite_line_sched.sv
// Bench for sprite_line_sched: schedule model plus
// directed line scenarios with literal expectations.
module tb_sprite_line_sched;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        line_start = 1'b0;
  logic [9:0]  vpos = '0;
  logic [19:0] spr_y = '0;
  logic [3:0]  spr_img = '0;
  logic [1:0]  spr_en = '0;
  logic [15:0] row_data;
  logic [1:0]  row_hit;
  logic        busy;
  logic        done;
  logic        overrun;

  int checks = 0;
  int failures = 0;

  sprite_line_sched_if #(.AW(6), .DW(8)) rif ();

  sprite_line_sched #(
    .SPR_N(2), .SPR_W(8), .SPR_H(16),
    .IMG_W(2), .Y_W(10)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .line_start (line_start),
    .vpos       (vpos),
    .spr_y      (spr_y),
    .spr_img    (spr_img),
    .spr_en     (spr_en),
    .rom        (rif),
    .row_data   (row_data),
    .row_hit    (row_hit),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_f(input logic [5:0] a);
    logic [15:0] p;
    p = 16'(a) * 16'd37 + 16'd11;
    return p[7:0];
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn)          rif.rom_data <= '0;
    else if (rif.rom_rd)  rif.rom_data <= rom_f(rif.rom_addr);
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Schedule that a line accepted right now would follow
  logic [1:0]  c_hit;
  logic [5:0]  c_addr [2];
  int          c_st [2];
  logic [15:0] c_row;
  int          c_tot;

  always_comb begin
    int s;
    logic [9:0] d;
    s = 1;
    c_hit = '0;
    c_row = '0;
    for (int i = 0; i < 2; i++) begin
      d = vpos - spr_y[i*10 +: 10];
      c_addr[i] = '0;
      c_st[i] = s;
      if (spr_en[i] && d < 10'd16) begin
        c_hit[i] = 1'b1;
        c_addr[i] = {spr_img[i*2 +: 2], d[3:0]};
        c_row[i*8 +: 8] = rom_f(c_addr[i]);
        s = s + 2;
      end else begin
        s = s + 1;
      end
    end
    c_tot = s - 1;
  end

  logic        m_act, m_done, m_ovr;
  int          m_t, m_tot;
  logic [1:0]  m_hit, m_pub_hit;
  logic [5:0]  m_addr [2];
  int          m_st [2];
  logic [15:0] m_row, m_pub_row;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_act <= 1'b0;
      m_done <= 1'b0;
      m_ovr <= 1'b0;
      m_t <= 0;
      m_tot <= 0;
      m_hit <= '0;
      m_pub_hit <= '0;
      m_row <= '0;
      m_pub_row <= '0;
      for (int i = 0; i < 2; i++) begin
        m_addr[i] <= '0;
        m_st[i] <= 0;
      end
    end else begin
      m_done <= 1'b0;
      if (line_start && m_act) m_ovr <= 1'b1;
      if (m_act) begin
        m_t <= m_t + 1;
        if (m_t + 1 == m_tot + 2) begin
          m_act <= 1'b0;
          m_done <= 1'b1;
          m_pub_row <= m_row;
          m_pub_hit <= m_hit;
        end
      end else if (line_start) begin
        m_act <= 1'b1;
        m_t <= 1;
        m_tot <= c_tot;
        m_hit <= c_hit;
        m_row <= c_row;
        m_addr <= c_addr;
        m_st <= c_st;
      end
    end
  end

  logic prev_rd = 1'b0;

  always @(negedge clk) begin
    logic       e_rd;
    logic [5:0] e_addr;
    e_rd = 1'b0;
    e_addr = '0;
    if (m_act) begin
      for (int i = 0; i < 2; i++) begin
        if (m_hit[i] && m_st[i] == m_t) begin
          e_rd = 1'b1;
          e_addr = m_addr[i];
        end
      end
    end
    chk("busy", busy, m_act);
    chk("rom_rd", rif.rom_rd, e_rd);
    chk("rom_addr", rif.rom_addr, e_addr);
    chk("done", done, m_done);
    chk("row_data", row_data, m_pub_row);
    chk("row_hit", row_hit, m_pub_hit);
    chk("overrun", overrun, m_ovr);
    if (prev_rd) chk("rom_b2b", rif.rom_rd, 0);
    prev_rd = rif.rom_rd;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic start(input logic [9:0] v);
    vpos = v;
    line_start = 1'b1;
    step();
    line_start = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    steps(2);
    resetn = 1'b1;
    steps(2);
    chk("rst_busy", busy, 0);
    chk("rst_hit", row_hit, 0);
    chk("rst_ovr", overrun, 0);

    // both slots hit
    spr_en = 2'b11;
    spr_y = {10'd100, 10'd100};
    spr_img = {2'd1, 2'd0};
    start(10'd105);
    chk("t1_rd_c1", rif.rom_rd, 1);
    chk("t1_addr_c1", rif.rom_addr, 6'h05);
    steps(2);
    chk("t1_addr_c3", rif.rom_addr, 6'h15);
    steps(2);
    chk("t1_nodone_c5", done, 0);
    step();
    chk("t1_done_c6", done, 1);
    chk("t1_hit", row_hit, 2'b11);
    chk("t1_row", row_data, 16'h14C4);
    steps(2);

    // both miss, above and below
    start(10'd99);
    chk("t2a_rd_c1", rif.rom_rd, 0);
    steps(3);
    chk("t2a_done_c4", done, 1);
    chk("t2a_hit", row_hit, 0);
    chk("t2a_row", row_data, 0);
    steps(2);
    start(10'd116);
    steps(3);
    chk("t2b_done_c4", done, 1);
    chk("t2b_hit", row_hit, 0);
    steps(2);
    start(10'd115);
    chk("t2c_addr_c1", rif.rom_addr, 6'h0F);
    steps(5);
    chk("t2c_done_c6", done, 1);
    chk("t2c_row", row_data, 16'h8636);
    steps(2);

    // wraparound and disabled slot
    spr_y = {10'd1020, 10'd1020};
    spr_en = 2'b01;
    start(10'd3);
    chk("t3_addr_c1", rif.rom_addr, 6'h07);
    steps(2);
    chk("t3_rd_c3", rif.rom_rd, 0);
    steps(2);
    chk("t3_done_c5", done, 1);
    chk("t3_hit", row_hit, 2'b01);
    chk("t3_row", row_data, 16'h000E);
    steps(2);

    // overrun
    spr_y = {10'd100, 10'd100};
    spr_en = 2'b11;
    chk("t4_ovr_pre", overrun, 0);
    start(10'd105);
    steps(2);
    line_start = 1'b1;
    step();
    line_start = 1'b0;
    chk("t4_ovr_c4", overrun, 1);
    steps(2);
    chk("t4_done_c6", done, 1);
    steps(2);
    start(10'd105);
    steps(5);
    chk("t4b_done_c6", done, 1);
    chk("t4b_ovr", overrun, 1);
    steps(2);

    // reset while slot 1 waits on ROM
    spr_y = {10'd100, 10'd500};
    start(10'd105);
    steps(2);
    resetn = 1'b0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_rd", rif.rom_rd, 0);
    chk("t5_row", row_data, 0);
    chk("t5_hit", row_hit, 0);
    chk("t5_ovr", overrun, 0);
    steps(2);
    chk("t5_nodone", done, 0);
    resetn = 1'b1;
    step();
    spr_y = {10'd100, 10'd100};
    start(10'd105);
    steps(5);
    chk("t5b_done_c6", done, 1);
    chk("t5b_row", row_data, 16'h14C4);
    steps(2);

    // double buffering across an image change
    spr_img = {2'd2, 2'd3};
    start(10'd105);
    steps(4);
    chk("t6_old_c5", row_data, 16'h14C4);
    step();
    chk("t6_done_c6", done, 1);
    chk("t6_new_c6", row_data, 16'h64B4);
    steps(2);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
